// File: rtl/mem_stage_param.sv
// Memory-access pipeline stage: byte-addressed data RAM with sub-word loads/stores,
// misalignment trapping, optional wait states with upstream stall, and the MEM/WB register.
module mem_stage_param #(
  parameter int DEPTH_LOG2  = 10,
  parameter int REG_AW      = 5,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_m,
  input  logic              flush_m,
  input  logic [31:0]       alu_out_m,
  input  logic [31:0]       wd_m,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [1:0]        mem_size_m,
  input  logic              mem_unsigned_m,
  input  logic              result_src_m,
  input  logic              rf_we_m,
  input  logic [REG_AW-1:0] rd_m,
  output logic              stall_m,
  output logic              valid_wb,
  output logic [31:0]       alu_out_wb,
  output logic [31:0]       load_data_wb,
  output logic              result_src_wb,
  output logic              rf_we_wb,
  output logic [REG_AW-1:0] rd_wb,
  output logic              misalign_wb
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [31:0] mem [WORDS];

  logic [DEPTH_LOG2-1:0] widx;
  logic [1:0]  lane;
  logic        access;
  logic        misalign;
  logic        complete;
  logic        do_store;
  logic [31:0] rword;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] rext;
  logic [3:0]  be;
  logic [31:0] wlane;

  logic              valid_d, result_src_d, rf_we_d, misalign_d;
  logic [31:0]       alu_out_d, load_data_d;
  logic [REG_AW-1:0] rd_d;
  logic              valid_q, result_src_q, rf_we_q, misalign_q;
  logic [31:0]       alu_out_q, load_data_q;
  logic [REG_AW-1:0] rd_q;

  assign widx   = alu_out_m[DEPTH_LOG2+1:2];
  assign lane   = alu_out_m[1:0];
  assign access = valid_m & (mem_read_m | mem_write_m);
  assign misalign = (mem_read_m | mem_write_m) &
                    (((mem_size_m == 2'b01) & lane[0]) | (mem_size_m[1] & (lane != 2'b00)));

  assign rword = mem[widx];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    rbyte = rword[7:0];
    case (lane)
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      2'd3:    rbyte = rword[31:24];
      default: rbyte = rword[7:0];
    endcase
  end

  always_comb begin
    rext  = rword;
    be    = 4'b1111;
    wlane = wd_m;
    case (mem_size_m)
      2'b00: begin
        rext  = {{24{~mem_unsigned_m & rbyte[7]}}, rbyte};
        be    = 4'b0001 << lane;
        wlane = {4{wd_m[7:0]}};
      end
      2'b01: begin
        rext  = {{16{~mem_unsigned_m & rhalf[15]}}, rhalf};
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wd_m[15:0]}};
      end
      default: begin
        rext  = rword;
        be    = 4'b1111;
        wlane = wd_m;
      end
    endcase
  end

  // The instruction in MEM only takes effect on its completion edge; every
  // other cycle (wait, flush, reset) pushes a bubble into WB.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_m  = 1'b0;
    complete = 1'b0;
    if (flush_m) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else if (WAIT_STATES == 0) begin
      complete = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            state_d = WAIT;
            cnt_d   = WS;
            stall_m = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            complete = 1'b1;
            state_d  = IDLE;
            cnt_d    = 4'd0;
          end else begin
            stall_m = 1'b1;
            cnt_d   = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
    if (rst) begin
      stall_m  = 1'b0;
      complete = 1'b0;
    end
  end

  assign do_store = complete & valid_m & mem_write_m & ~misalign;

  always_comb begin
    valid_d      = 1'b0;
    alu_out_d    = 32'd0;
    load_data_d  = 32'd0;
    result_src_d = 1'b0;
    rf_we_d      = 1'b0;
    rd_d         = '0;
    misalign_d   = 1'b0;
    if (complete & valid_m) begin
      valid_d      = 1'b1;
      alu_out_d    = alu_out_m;
      load_data_d  = misalign ? 32'd0 : rext;
      result_src_d = result_src_m;
      rf_we_d      = rf_we_m & ~misalign;
      rd_d         = rd_m;
      misalign_d   = misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      valid_q      <= 1'b0;
      alu_out_q    <= 32'd0;
      load_data_q  <= 32'd0;
      result_src_q <= 1'b0;
      rf_we_q      <= 1'b0;
      rd_q         <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      alu_out_q    <= alu_out_d;
      load_data_q  <= load_data_d;
      result_src_q <= result_src_d;
      rf_we_q      <= rf_we_d;
      rd_q         <= rd_d;
      misalign_q   <= misalign_d;
    end
  end

  // Memory contents survive reset; do_store is already blocked while rst is high.
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign valid_wb      = valid_q;
  assign alu_out_wb    = alu_out_q;
  assign load_data_wb  = load_data_q;
  assign result_src_wb = result_src_q;
  assign rf_we_wb      = rf_we_q;
  assign rd_wb         = rd_q;
  assign misalign_wb   = misalign_q;

endmodule

// File: tb/tb_mem_stage_param.sv
// Bench for mem_stage_param: one zero-wait instance (1K words) and one three-wait
// instance (16 words), checked against a byte-array reference model.
module tb_mem_stage_param;

  typedef struct packed {
    logic        v;
    logic        fl;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        un;
    logic        rs;
    logic        we;
    logic [4:0]  rdi;
  } op_t;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] ld;
    logic        rs;
    logic        we;
    logic [4:0]  rdi;
    logic        mis;
  } wb_t;

  logic clk = 1'b0;
  logic rst;
  op_t  in0, in1;
  wb_t  w0, w1;
  logic stall0, stall1;

  int checks = 0;
  int failures = 0;

  logic [7:0] m0 [4096];
  logic [7:0] m1 [64];

  always #5 clk = ~clk;

  mem_stage_param #(.DEPTH_LOG2(10), .REG_AW(5), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .valid_m(in0.v), .flush_m(in0.fl), .alu_out_m(in0.a),
    .wd_m(in0.wd), .mem_read_m(in0.rd), .mem_write_m(in0.wr), .mem_size_m(in0.sz),
    .mem_unsigned_m(in0.un), .result_src_m(in0.rs), .rf_we_m(in0.we), .rd_m(in0.rdi),
    .stall_m(stall0), .valid_wb(w0.v), .alu_out_wb(w0.a), .load_data_wb(w0.ld),
    .result_src_wb(w0.rs), .rf_we_wb(w0.we), .rd_wb(w0.rdi), .misalign_wb(w0.mis)
  );

  mem_stage_param #(.DEPTH_LOG2(4), .REG_AW(5), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst), .valid_m(in1.v), .flush_m(in1.fl), .alu_out_m(in1.a),
    .wd_m(in1.wd), .mem_read_m(in1.rd), .mem_write_m(in1.wr), .mem_size_m(in1.sz),
    .mem_unsigned_m(in1.un), .result_src_m(in1.rs), .rf_we_m(in1.we), .rd_m(in1.rdi),
    .stall_m(stall1), .valid_wb(w1.v), .alu_out_wb(w1.a), .load_data_wb(w1.ld),
    .result_src_wb(w1.rs), .rf_we_wb(w1.we), .rd_wb(w1.rdi), .misalign_wb(w1.mis)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input int inst, input int idx);
    return (inst == 0) ? m0[idx] : m1[idx];
  endfunction

  task automatic set_byte(input int inst, input int idx, input logic [7:0] val);
    if (inst == 0) m0[idx] = val;
    else m1[idx] = val;
  endtask

  // Reference: byte-addressed memory of 4*2^DEPTH_LOG2 bytes; addresses wrap modulo its size.
  task automatic model(input int inst, input op_t op, output wb_t e);
    int unsigned nb, base, nbytes, amod;
    logic mis;
    logic [31:0] val;
    nb = (inst == 0) ? 4096 : 64;
    nbytes = (op.sz == 2'b00) ? 1 : (op.sz == 2'b01) ? 2 : 4;
    amod = op.a % nb;
    mis = (op.rd || op.wr) && ((op.a % nbytes) != 0);
    base = amod - (amod % nbytes);
    e = '0;
    if (op.v) begin
      val = 32'd0;
      for (int i = 0; i < int'(nbytes); i++) val[8*i +: 8] = mbyte(inst, int'(base) + i);
      if (!op.un && nbytes == 1 && val[7]) val = val | 32'hFFFFFF00;
      if (!op.un && nbytes == 2 && val[15]) val = val | 32'hFFFF0000;
      e.v   = 1'b1;
      e.a   = op.a;
      e.ld  = mis ? 32'd0 : val;
      e.rs  = op.rs;
      e.we  = op.we && !mis;
      e.rdi = op.rdi;
      e.mis = mis;
      if (op.wr && !mis)
        for (int i = 0; i < int'(nbytes); i++) set_byte(inst, int'(base) + i, op.wd[8*i +: 8]);
    end
  endtask

  task automatic issue(input string tag, input int inst, input op_t op, output wb_t got);
    wb_t e;
    int exp_stall, cycles;
    logic s;
    model(inst, op, e);
    exp_stall = (inst == 1 && op.v && (op.rd || op.wr)) ? 3 : 0;
    if (inst == 0) in0 = op;
    else in1 = op;
    cycles = 0;
    while (1) begin
      @(negedge clk);
      if (cycles > 0) check({tag, "_bubble"}, {95'd0, (inst == 0) ? w0.v : w1.v}, 96'd0);
      s = (inst == 0) ? stall0 : stall1;
      if (!s) break;
      cycles++;
      if (cycles > 20) break;
    end
    check({tag, "_stalls"}, 96'(cycles), 96'(exp_stall));
    @(posedge clk);
    #1;
    got = (inst == 0) ? w0 : w1;
    check({tag, "_ctl"}, {got.v, got.a, got.rs, got.we, got.rdi, got.mis},
                         {e.v, e.a, e.rs, e.we, e.rdi, e.mis});
    if (op.v && op.rd) check({tag, "_ld"}, 96'(got.ld), 96'(e.ld));
    $display("%s inst=%0d a=%h rd=%0d wr=%0d sz=%0d v=%0d ld=%h we=%0d mis=%0d stalls=%0d",
             tag, inst, op.a, op.rd, op.wr, op.sz, op.v, got.ld, got.we, got.mis, cycles);
    if (inst == 0) in0 = '0;
    else in1 = '0;
  endtask

  function automatic op_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic un, input logic [31:0] a, input logic [31:0] wd,
                             input logic we, input logic [4:0] rdi);
    op_t o;
    o = '0;
    o.v = 1'b1; o.rd = rd; o.wr = wr; o.sz = sz; o.un = un;
    o.a = a; o.wd = wd; o.we = we; o.rdi = rdi; o.rs = rd;
    return o;
  endfunction

  function automatic op_t rand_op(input int inst);
    op_t o;
    int kind;
    o = '0;
    kind = int'($urandom_range(0, 2));
    o.v   = ($urandom_range(0, 9) != 0);
    o.rd  = (kind == 0);
    o.wr  = (kind == 1);
    o.sz  = 2'($urandom_range(0, 3));
    o.un  = 1'($urandom_range(0, 1));
    o.rs  = 1'($urandom_range(0, 1));
    o.we  = 1'($urandom_range(0, 1));
    o.rdi = 5'($urandom_range(0, 31));
    o.wd  = $urandom;
    if (inst == 0) o.a = (32'h100 + 32'($urandom_range(0, 63))) | ($urandom << 12);
    else o.a = $urandom;
    return o;
  endfunction

  initial begin
    wb_t g;
    op_t o;
    rst = 1'b1;
    in0 = '0;
    in1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb0", 96'(w0), 96'd0);
    check("rst_wb1", 96'(w1), 96'd0);
    check("rst_stall", {94'd0, stall0, stall1}, 96'd0);
    rst = 1'b0;

    // Word path and sub-word accesses on the zero-wait instance
    issue("sw", 0, mk(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0), g);
    issue("lw", 0, mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 7), g);
    check("lw_dir", {g.ld, g.rdi, g.we, g.v}, {32'hDEADBEEF, 5'd7, 1'b1, 1'b1});
    issue("sb", 0, mk(0, 1, 2'b00, 0, 32'h13, 32'h80, 0, 0), g);
    issue("lb", 0, mk(1, 0, 2'b00, 0, 32'h13, 32'h0, 1, 3), g);
    check("lb_dir", 96'(g.ld), 96'(32'hFFFFFF80));
    issue("lbu", 0, mk(1, 0, 2'b00, 1, 32'h13, 32'h0, 1, 3), g);
    check("lbu_dir", 96'(g.ld), 96'(32'h00000080));
    issue("lh", 0, mk(1, 0, 2'b01, 0, 32'h12, 32'h0, 1, 4), g);
    check("lh_dir", 96'(g.ld), 96'(32'hFFFF80AD));
    issue("lw2", 0, mk(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 5), g);
    check("lw2_dir", 96'(g.ld), 96'(32'h80ADBEEF));

    // Misalignment
    issue("sw20", 0, mk(0, 1, 2'b10, 0, 32'h20, 32'h11223344, 0, 0), g);
    issue("sw22", 0, mk(0, 1, 2'b10, 0, 32'h22, 32'hAAAAAAAA, 0, 0), g);
    issue("lw20", 0, mk(1, 0, 2'b10, 0, 32'h20, 32'h0, 1, 1), g);
    check("mis_st_dir", 96'(g.ld), 96'(32'h11223344));
    issue("lh21", 0, mk(1, 0, 2'b01, 0, 32'h21, 32'h0, 1, 2), g);
    check("mis_ld_dir", {g.mis, g.we, g.ld}, {1'b1, 1'b0, 32'h0});

    // Random traffic on the zero-wait instance over a pre-filled region
    for (int i = 0; i < 16; i++)
      issue("fill0", 0, mk(0, 1, 2'b10, 0, 32'h100 + 32'(4 * i), $urandom, 0, 0), g);
    for (int i = 0; i < 60; i++) issue("rnd0", 0, rand_op(0), g);

    // Wait-state instance
    for (int i = 0; i < 16; i++)
      issue("fill1", 1, mk(0, 1, 2'b10, 0, 32'(4 * i), $urandom, 0, 0), g);
    o = '0;
    o.v = 1'b1; o.a = 32'h55; o.we = 1'b1; o.rdi = 5'd9;
    issue("alu1", 1, o, g);
    issue("lw1", 1, mk(1, 0, 2'b10, 0, 32'h8, 32'h0, 1, 6), g);
    issue("sw44", 1, mk(0, 1, 2'b10, 0, 32'h44, 32'hCAFEF00D, 0, 0), g);
    issue("lw04", 1, mk(1, 0, 2'b10, 0, 32'h04, 32'h0, 1, 8), g);
    check("alias_dir", 96'(g.ld), 96'(32'hCAFEF00D));

    // Flush on the second stall cycle of a store
    in1 = mk(0, 1, 2'b10, 0, 32'h40, 32'h12345678, 0, 0);
    @(posedge clk);
    #1;
    in1.fl = 1'b1;
    #1;
    check("flush_stall", 96'(stall1), 96'd0);
    @(posedge clk);
    #1;
    check("flush_bubble", 96'(w1), 96'd0);
    in1 = '0;
    issue("lw40", 1, mk(1, 0, 2'b10, 0, 32'h40, 32'h0, 1, 10), g);

    // Reset while waiting
    in1 = mk(1, 0, 2'b10, 0, 32'h0C, 32'h0, 1, 11);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in1 = '0;
    #1;
    check("rstw_stall_now", 96'(stall1), 96'd0);
    @(posedge clk);
    #1;
    check("rstw_wb", 96'(w1), 96'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstw_stall_next", 96'(stall1), 96'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) issue("rnd1", 1, rand_op(1), g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_param.md
Name: mem_stage_param

Overview:
- Parametrised memory-access stage of the 5-stage pipeline.
- Contains the byte-addressed data memory and the MEM/WB pipeline register.
- Adds sub-word loads and stores (byte/half/word) with sign or zero extension, and misalignment trapping.
- Adds configurable memory wait states with upstream stall, plus flush, valid tracking and parametrised depth and register-index width.

Parameters:
- DEPTH_LOG2, 10, data memory holds 2^DEPTH_LOG2 32-bit words.
- REG_AW, 5, destination register index width.
- WAIT_STATES, 0, extra cycles per load/store (0..15); 0 means single-cycle access.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_m  in  1  instruction present in MEM.
- flush_m  in  1  squash the instruction in MEM.
- alu_out_m  in  32  byte address / ALU result.
- wd_m  in  32  store data, right-aligned.
- mem_read_m  in  1  load.
- mem_write_m  in  1  store.
- mem_size_m  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- mem_unsigned_m  in  1  zero-extend loads when 1.
- result_src_m  in  1  passed to WB.
- rf_we_m  in  1  register write enable.
- rd_m  in  REG_AW  destination register.
- stall_m  out  1  upstream must hold all MEM inputs stable.
- valid_wb  out  1  WB holds a real instruction.
- alu_out_wb  out  32  registered ALU result.
- load_data_wb  out  32  registered, extended load data.
- result_src_wb  out  1  registered.
- rf_we_wb  out  1  registered, qualified write enable.
- rd_wb  out  REG_AW  registered.
- misalign_wb  out  1  registered misalignment flag.

Behaviour:
- Reset: synchronous, active-high. All WB outputs go to 0 and FSM = IDLE. stall_m = 0. Memory contents are not cleared.
- Addressing:
  - Word index = alu_out_m[DEPTH_LOG2+1:2]; upper bits are ignored (aliasing).
  - Byte lane = alu_out_m[1:0]; little-endian.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0 (load or store).
  - Store is suppressed.
  - load_data = 0.
  - misalign_wb = 1.
  - rf_we_wb = 0.
- Reads: combinational from array.
  - Byte: selected lane.
  - Half: lane pair.
  - Word: full word.
  - Sign-extend unless mem_unsigned_m.
- Writes: synchronous on the completion edge only, using per-byte enables.
  - SB writes wd_m[7:0] to the addressed lane.
  - SH writes wd_m[15:0] to lanes {1,0} or {3,2}.
  - SW writes all lanes.
- Access = valid_m & (mem_read_m | mem_write_m).
- FSM, WAIT_STATES>0:
  - IDLE:
    - If access & !flush_m: enter WAIT with cnt = WAIT_STATES, stall_m = 1.
    - Otherwise the instruction completes this cycle.
  - WAIT:
    - stall_m = 1 and WB loads a bubble (valid_wb=0, rf_we_wb=0) each cycle.
    - cnt decrements by 1 per cycle.
    - When cnt==1, the next edge is the completion edge: stall_m deasserts (combinational on cnt==1) and the FSM returns to IDLE.
  - Total occupancy of an access = WAIT_STATES+1 cycles.
  - Non-memory instructions never stall.
- WAIT_STATES=0: FSM stays IDLE; stall_m is constant 0.
- Completion edge: WB register loads:
  - valid_wb = valid_m.
  - alu_out_wb, result_src_wb, rd_wb taken from MEM inputs.
  - load_data_wb = extended read data.
  - rf_we_wb = rf_we_m & valid_m & !misalign.
- flush_m: a flush in any state:
  - WB loads a bubble (all fields 0).
  - No store occurs.
  - FSM goes to IDLE.
  - stall_m = 0 in that cycle.
- Priority: rst > flush_m > normal.
- Invalid input (valid_m=0): WB loads a bubble; no store.
- Load followed by store to the same address on consecutive instructions: the load sees the old data.
- Store then load: the load sees the new data on the following instruction.
- Input changes during WAIT are a protocol violation; behaviour is undefined.

Test Plan:
- Reset & word path, WAIT_STATES=0:
  - Assert rst 2 cycles -> all WB outputs 0.
  - SW 0xDEADBEEF at 0x10, then LW 0x10, rf_we_m=1, rd_m=7 -> next cycle load_data_wb=0xDEADBEEF, rd_wb=7, rf_we_wb=1, valid_wb=1.
- Sub-word access:
  - SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFF80.
  - LBU 0x13 -> 0x00000080.
  - LH 0x12 -> 0xFFFF80AD.
  - LW 0x10 -> 0x80ADBEEF.
- Misalignment:
  - SW to 0x22 -> memory word 0x20 unchanged.
  - LH 0x21 with rf_we_m=1 -> misalign_wb=1, rf_we_wb=0, load_data_wb=0.
- Wait states, WAIT_STATES=3:
  - LW issued -> stall_m high for 3 cycles and valid_wb=0 during them.
  - Data appears in WB on cycle 4.
  - ALU-only op -> no stall.
- Flush mid-wait, WAIT_STATES=3:
  - SW 0x12345678 to 0x40, flush_m on 2nd stall cycle -> stall_m drops.
  - Word 0x40 unchanged; valid_wb=0.
  - FSM accepts a new instruction next cycle.
- Reset mid-operation & aliasing:
  - rst during WAIT -> WB cleared, stall_m=0 next cycle.
  - With DEPTH_LOG2=4: SW to 0x44, then LW 0x04 -> same data returned.
